// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared types and default sizes for the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_array
// Description : Word storage, synchronous write and registered read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read register only moves on a read, so it holds across writes.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule : mem_resp_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with optional wait states.
//               Define MEM_RESP_WAIT_EN to build the WAIT state and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rd_valid;
    logic                w_accept;
    logic                w_enter_ack;
    logic                w_op_write;
    logic [ADDR_W-1:0]   w_op_addr;
    logic [DATA_W-1:0]   w_op_wdata;
    logic                w_arr_we;
    logic                w_arr_re;
    logic [DATA_W-1:0]   w_arr_rdata;

    assign w_accept    = (r_state == IDLE) && req;
    assign w_enter_ack = (w_next == ACK);

    // With no wait states ACK is entered on the acceptance edge itself,
    // so the live inputs must reach the array directly.
    assign w_op_write = (r_state == IDLE) ? write : r_write;
    assign w_op_addr  = (r_state == IDLE) ? addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? wdata : r_wdata;

    assign w_arr_we = w_enter_ack &&  w_op_write;
    assign w_arr_re = w_enter_ack && !w_op_write;

`ifdef MEM_RESP_WAIT_EN
    localparam int                c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD =
        (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end
`else
    logic w_unused_wait_cfg;
    assign w_unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
`ifdef MEM_RESP_WAIT_EN
                    w_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
`else
                    w_next = ACK;
`endif
                end
            end
            WAIT: begin
`ifdef MEM_RESP_WAIT_EN
                if (r_cnt == '0) begin
                    w_next = ACK;
                end
`else
                w_next = IDLE;
`endif
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ack   = (r_state == ACK);
        busy  = (r_state != IDLE);
        rdata = r_rd_valid ? w_arr_rdata : '0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= write;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // The array read register has no reset; this flag masks it to zero
    // until the first read after reset.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_rd_valid <= 1'b0;
        end else if (w_arr_re) begin
            r_rd_valid <= 1'b1;
        end
    end

    mem_resp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (w_arr_we),
        .re    (w_arr_re),
        .addr  (w_op_addr),
        .wdata (w_op_wdata),
        .rdata (w_arr_rdata)
    );

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Randomized self-checking bench for mem_responder against a
//               transaction-timeline model. Honours MEM_RESP_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 9;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << ADDR_W;
`ifdef MEM_RESP_WAIT_EN
    localparam int EFF_WAIT = WAIT_CYCLES;
`else
    localparam int EFF_WAIT = 0;
`endif

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic              req   = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    always #5 clock = ~clock;

    mem_responder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clock (clock),
        .clear (clear),
        .req   (req),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction occupies EFF_WAIT+1 busy cycles, ack in the last;
    // its effect on storage/rdata lands on the edge that starts the ack cycle.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    int                m_left     = 0;
    logic              m_wr       = 1'b0;
    logic [ADDR_W-1:0] m_addr     = '0;
    logic [DATA_W-1:0] m_wdata    = '0;
    logic [DATA_W-1:0] m_rdata    = '0;
    bit                m_rd_known = 1'b1;

    task automatic model_complete();
        if (m_wr) begin
            m_mem[m_addr]   = m_wdata;
            m_known[m_addr] = 1'b1;
        end else begin
            m_rdata    = m_mem[m_addr];
            m_rd_known = m_known[m_addr];
        end
    endtask

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_left     = 0;
            m_rdata    = '0;
            m_rd_known = 1'b1;
        end else if (m_left == 0) begin
            if (req) begin
                m_wr    = write;
                m_addr  = addr;
                m_wdata = wdata;
                m_left  = EFF_WAIT + 1;
                if (m_left == 1) model_complete();
            end
        end else begin
            m_left--;
            if (m_left == 1) model_complete();
        end
    end

    always @(negedge clock) begin
        check("ack", DATA_W'(ack), DATA_W'(m_left == 1));
        check("busy", DATA_W'(busy), DATA_W'(m_left > 0));
        if (m_rd_known) check("rdata", rdata, m_rdata);
    end

    logic [ADDR_W-1:0] pool [8];

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clock);
        if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%b expected 0", busy);
        end
    endtask

    task automatic txn(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit scramble,
                       output int lat, output logic [DATA_W-1:0] rd);
        @(negedge clock);
        wait_idle();
        req = 1'b1; write = wr; addr = a; wdata = d;
        lat = 0;
        rd  = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                lat = i;
                rd  = rdata;
                break;
            end
            if (scramble) begin
                write = 1'($urandom);
                addr  = ADDR_W'($urandom);
                wdata = $urandom;
            end
        end
        req = 1'b0;
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: no ack within 40 cycles, expected %0d", EFF_WAIT + 1);
        end
    endtask

    // Reads with req held high; each ack re-arms the next address.
    task automatic burst(input int n);
        int last = 0;
        int t    = 0;
        int got  = 0;
        @(negedge clock);
        wait_idle();
        req = 1'b1; write = 1'b0; addr = pool[$urandom_range(0, 7)];
        while (got < n && t < 40 * n) begin
            @(negedge clock);
            t++;
            if (ack === 1'b1) begin
                if (got == 0) check("burst_first", 32'(t - last), 32'(EFF_WAIT + 1));
                else          check("burst_gap",   32'(t - last), 32'(EFF_WAIT + 2));
                last = t;
                got++;
                addr = pool[$urandom_range(0, 7)];
                if (got == n) req = 1'b0;
            end
        end
        req = 1'b0;
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL burst_timeout: acks=%0d expected %0d", got, n);
        end
    endtask

    // Called just after a rising edge; asserts clear between edges.
    task automatic pulse_reset();
        #2 clear = 1'b0;
        #1;
        check("rst_ack",   DATA_W'(ack),  '0);
        check("rst_busy",  DATA_W'(busy), '0);
        check("rst_rdata", rdata, 32'h0000_0000);
        req = 1'b0;
        @(posedge clock);
        #2 clear = 1'b1;
    endtask

    initial begin
        int                lat;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] exp_abort;

        pool = '{9'h0A5, 9'h010, 9'h000, 9'h1FF, 9'h055, 9'h100, 9'h0FE, 9'h001};

        repeat (3) @(negedge clock);
        check("reset_ack",   DATA_W'(ack),  '0);
        check("reset_busy",  DATA_W'(busy), '0);
        check("reset_rdata", rdata, '0);
        @(posedge clock);
        #2 clear = 1'b1;

        txn(1'b1, 9'h0A5, 32'hDEAD_BEEF, 1'b0, lat, rd);
        check("wr_latency", 32'(lat), 32'(EFF_WAIT + 1));
        txn(1'b0, 9'h0A5, 32'h0, 1'b0, lat, rd);
        check("rd_latency", 32'(lat), 32'(EFF_WAIT + 1));
        check("rd_deadbeef", rd, 32'hDEAD_BEEF);

        txn(1'b1, 9'h0A5, 32'h1234_5678, 1'b1, lat, rd);
        check("wr_keeps_rdata", rd, 32'hDEAD_BEEF);
        txn(1'b0, 9'h0A5, 32'h0, 1'b1, lat, rd);
        check("rd_after_scramble", rd, 32'h1234_5678);

        txn(1'b1, 9'h010, 32'h1111_1111, 1'b0, lat, rd);
        @(negedge clock);
        wait_idle();
        req = 1'b1; write = 1'b1; addr = 9'h010; wdata = 32'h2222_2222;
        @(posedge clock);
        pulse_reset();
        txn(1'b0, 9'h010, 32'h0, 1'b0, lat, rd);
`ifdef MEM_RESP_WAIT_EN
        exp_abort = 32'h1111_1111;
`else
        exp_abort = 32'h2222_2222;
`endif
        check("abort_write", rd, exp_abort);

        for (int i = 0; i < 8; i++) txn(1'b1, pool[i], $urandom, 1'b0, lat, rd);
        burst(4);

        for (int it = 0; it < 300; it++) begin
            int sel;
            logic [ADDR_W-1:0] a;
            sel = $urandom_range(0, 99);
            a   = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom) : pool[$urandom_range(0, 7)];
            if (sel < 8) begin
                burst($urandom_range(2, 4));
            end else if (sel < 11) begin
                @(negedge clock);
                wait_idle();
                req = 1'b1; write = 1'($urandom); addr = a; wdata = $urandom;
                repeat ($urandom_range(1, 3)) @(posedge clock);
                pulse_reset();
            end else begin
                txn(1'($urandom), a, $urandom, 1'($urandom), lat, rd);
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
